reorder_buffer: RTL

Seven-entry in-order retirement buffer that produces the rename tags consumed by the register file. Each issued instruction receives a 3-bit tag on `dependency_num`. Execution results arrive later by tag, in any order. Entries retire strictly in program order onto the register file's commit port (`commit`, `reg_num`, `data_in`, `num_in`). The buffer also answers operand-tag queries so that dispatch can resolve a pending operand without waiting for retirement.

---
 rtl/reorder_buffer_if.sv | 42 ++++
 rtl/reorder_buffer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// Issue, writeback, operand-query and commit bundle of the reorder buffer.
// The master side drives requests; the buffer itself sits on the slave side.
interface reorder_buffer_if;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [2:0]  dependency_num;

    logic        wb_valid;
    logic [2:0]  wb_tag;
    logic [31:0] wb_data;

    logic [2:0]  query1;
    logic [2:0]  query2;
    logic        q1_ready;
    logic        q2_ready;
    logic [31:0] q1_value;
    logic [31:0] q2_value;

    logic        commit;
    logic [4:0]  reg_num;
    logic [31:0] data_in;
    logic [2:0]  num_in;

    modport master (
        output issue_valid, issue_rd,
        output wb_valid, wb_tag, wb_data,
        output query1, query2,
        input  issue_ready, dependency_num,
        input  q1_ready, q2_ready, q1_value, q2_value,
        input  commit, reg_num, data_in, num_in
    );

    modport slave (
        input  issue_valid, issue_rd,
        input  wb_valid, wb_tag, wb_data,
        input  query1, query2,
        output issue_ready, dependency_num,
        output q1_ready, q2_ready, q1_value, q2_value,
        output commit, reg_num, data_in, num_in
    );
endinterface

// File: rtl/reorder_buffer.sv
// Seven-entry in-order retirement buffer handing out rename tags 1..7.
// Results arrive by tag in any order; entries retire in order to the regfile.
module reorder_buffer (
    input  logic             clk,
    input  logic             rst,
    input  logic             pause,
    input  logic             flush,
    reorder_buffer_if.slave  rob
);

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [4:0]  rd;
        logic [31:0] value;
    } rob_entry_t;

    // Slot 0 exists only so a 3-bit tag indexes directly; it is never allocated.
    rob_entry_t  ent [8];

    logic [2:0]  head;
    logic [2:0]  tail;
    logic [3:0]  count;

    logic        commit_r;
    logic [4:0]  reg_num_r;
    logic [31:0] data_in_r;
    logic [2:0]  num_in_r;

    logic        full;
    logic        issue_fire;
    logic        wb_fire;
    logic        retire_fire;
    logic        retire_vis;

    function automatic logic [2:0] nxt(input logic [2:0] p);
        return (p == 3'd7) ? 3'd1 : p + 3'd1;
    endfunction

    function automatic logic [32:0] resolve(
        input logic [2:0]  tag,
        input rob_entry_t  e,
        input logic        wbv,
        input logic [2:0]  wbt,
        input logic [31:0] wbd
    );
        if (tag == 3'd0)
            return 33'd0;
        else if (e.busy && e.done)
            return {1'b1, e.value};
        else if (wbv && wbt == tag)
            return {1'b1, wbd};
        else
            return 33'd0;
    endfunction

    assign full        = (count == 4'd7);
    assign issue_fire  = rob.issue_valid && !full && !pause;
    assign wb_fire     = rob.wb_valid && rob.wb_tag != 3'd0
                         && ent[rob.wb_tag].busy;
    assign retire_fire = !pause && ent[head].busy && ent[head].done;
    assign retire_vis  = retire_fire && ent[head].rd != 5'd0;

    assign rob.issue_ready    = !full && !pause;
    assign rob.dependency_num = tail;

    assign {rob.q1_ready, rob.q1_value} =
        resolve(rob.query1, ent[rob.query1],
                rob.wb_valid, rob.wb_tag, rob.wb_data);
    assign {rob.q2_ready, rob.q2_value} =
        resolve(rob.query2, ent[rob.query2],
                rob.wb_valid, rob.wb_tag, rob.wb_data);

    assign rob.commit  = commit_r;
    assign rob.reg_num = reg_num_r;
    assign rob.data_in = data_in_r;
    assign rob.num_in  = num_in_r;

    // The slot being allocated is never busy, so a same-cycle writeback
    // to it is dropped by wb_fire and cannot collide with the issue write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++)
                ent[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < 8; i++)
                ent[i].busy <= 1'b0;
        end else begin
            if (wb_fire) begin
                ent[rob.wb_tag].done  <= 1'b1;
                ent[rob.wb_tag].value <= rob.wb_data;
            end
            if (retire_fire)
                ent[head].busy <= 1'b0;
            if (issue_fire) begin
                ent[tail].busy <= 1'b1;
                ent[tail].done <= 1'b0;
                ent[tail].rd   <= rob.issue_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= 3'd1;
            tail      <= 3'd1;
            count     <= 4'd0;
            commit_r  <= 1'b0;
            reg_num_r <= 5'd0;
            data_in_r <= 32'd0;
            num_in_r  <= 3'd0;
        end else if (flush) begin
            head     <= 3'd1;
            tail     <= 3'd1;
            count    <= 4'd0;
            commit_r <= 1'b0;
        end else begin
            commit_r <= retire_vis;
            if (retire_fire)
                head <= nxt(head);
            if (retire_vis) begin
                reg_num_r <= ent[head].rd;
                data_in_r <= ent[head].value;
                num_in_r  <= head;
            end
            if (issue_fire)
                tail <= nxt(tail);
            unique case ({issue_fire, retire_fire})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

endmodule
